// File: rtl/core_ctrl_pkg.sv
// Shared types and instruction-word layout for the core instruction sequencer.
package core_ctrl_pkg;

  localparam int unsigned INST_W    = 41;
  localparam int unsigned A_FIELD_W = 8;
  localparam int unsigned A_PMEM_W  = 9;
  localparam int unsigned SKEW_W    = 3;

  // Bit positions of every field in the core instruction word
  localparam int unsigned B_MAX_POOL    = 40;
  localparam int unsigned B_PSUM_BYPASS = 39;
  localparam int unsigned B_ACC         = 38;
  localparam int unsigned B_CEN_PMEM    = 37;
  localparam int unsigned B_WEN_PMEM    = 36;
  localparam int unsigned B_A_PMEM_LSB  = 27;
  localparam int unsigned B_CEN1        = 26;
  localparam int unsigned B_A1_LSB      = 18;
  localparam int unsigned B_CEN0        = 17;
  localparam int unsigned B_WEN0        = 16;
  localparam int unsigned B_A0_LSB      = 8;
  localparam int unsigned B_OFIFO_RD    = 7;
  localparam int unsigned B_IFIFO_WR    = 6;
  localparam int unsigned B_IFIFO_RD    = 5;
  localparam int unsigned B_L0_RD       = 4;
  localparam int unsigned B_L0_WR       = 3;
  localparam int unsigned B_MODE        = 2;
  localparam int unsigned B_EXECUTE     = 1;
  localparam int unsigned B_LOAD        = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    SHIFT   = 3'd2,
    FLUSH   = 3'd3,
    READOUT = 3'd4
  } state_t;

  // Core-control bits that trail the memory fields by the skew depth
  typedef struct packed {
    logic mode;
    logic execute;
    logic load;
  } skew_t;

  localparam logic [INST_W-1:0] INST_ONE = INST_W'(1);

  // Idle word: every memory disabled, every strobe low
  localparam logic [INST_W-1:0] INST_DEFAULT =
      (INST_ONE << B_CEN_PMEM) | (INST_ONE << B_WEN_PMEM) |
      (INST_ONE << B_CEN1)     | (INST_ONE << B_CEN0)     |
      (INST_ONE << B_WEN0);

endpackage

// File: rtl/core_inst_sequencer_if.sv
// Host-side control/status bundle of the core instruction sequencer.
interface core_inst_sequencer_if
  import core_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic              start;
  logic [ADDR_W-1:0] cfg_len_nij;
  logic              cfg_mode;
  logic              cfg_maxpool;
  logic              l0_ready;
  logic              ififo_ready;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_len_nij, cfg_mode, cfg_maxpool,
    output l0_ready, ififo_ready, ofifo_valid,
    input  inst, busy, done
  );

  modport slave (
    input  start, cfg_len_nij, cfg_mode, cfg_maxpool,
    input  l0_ready, ififo_ready, ofifo_valid,
    output inst, busy, done
  );

endinterface

// File: rtl/inst_skew_pipe.sv
// Fixed-depth delay line that lags mode/execute/load behind the memory fields.
module inst_skew_pipe #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/core_inst_sequencer.sv
// Generates the 41-bit core instruction stream for one output-stationary tile
// pass: operand fetch/execute, PE drain, skew flush and OFIFO readout.
module core_inst_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int unsigned       ROW          = 8,
  parameter int unsigned       COL          = 8,
  parameter int unsigned       ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] ACT_BASE     = 8'h00,
  parameter logic [ADDR_W-1:0] W_BASE       = 8'h80,
  parameter int unsigned       SHIFT_CYCLES = ROW + COL,
  parameter int unsigned       SKEW         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  core_inst_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = 16;

  state_t              state;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   k;
  logic                mode_q;
  logic                maxpool_q;
  logic [CNT_W-1:0]    phase_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic [INST_W-1:0]   inst_q;
  logic                busy_q;
  logic                done_q;
  logic                issue_c;
  skew_t               push_c;
  skew_t               skew_out;

  assign issue_c = (state == EXEC) && bus.l0_ready && bus.ififo_ready;

  // Control bits entering the skew line this cycle; stalls push execute=0
  always_comb begin
    push_c = '0;
    case (state)
      EXEC:    push_c = '{mode: mode_q, execute: issue_c, load: 1'b0};
      SHIFT:   push_c = '{mode: mode_q, execute: 1'b0,    load: 1'b1};
      default: push_c = '0;
    endcase
  end

  inst_skew_pipe #(
    .WIDTH (SKEW_W),
    .DEPTH (SKEW)
  ) u_skew (
    .clk   (clk),
    .reset (reset),
    .din   (push_c),
    .dout  (skew_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      k         <= '0;
      mode_q    <= 1'b0;
      maxpool_q <= 1'b0;
      phase_cnt <= '0;
      rd_cnt    <= '0;
      inst_q    <= INST_DEFAULT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Per-cycle defaults: memories disabled, readout strobes low
      done_q                 <= 1'b0;
      inst_q[B_CEN0]         <= 1'b1;
      inst_q[B_CEN1]         <= 1'b1;
      inst_q[B_OFIFO_RD]     <= 1'b0;
      inst_q[B_MAX_POOL]     <= 1'b0;
      inst_q[B_PSUM_BYPASS]  <= 1'b0;
      inst_q[B_ACC]          <= 1'b0;
      inst_q[B_A_PMEM_LSB +: A_PMEM_W] <= '0;

      // Strobes derived from the previous instruction word
      inst_q[B_L0_WR]    <= ~inst_q[B_CEN0] & inst_q[B_WEN0];
      inst_q[B_L0_RD]    <= inst_q[B_L0_WR];
      inst_q[B_IFIFO_WR] <= ~inst_q[B_CEN1];
      inst_q[B_IFIFO_RD] <= inst_q[B_IFIFO_WR];

      inst_q[B_MODE]    <= skew_out.mode;
      inst_q[B_EXECUTE] <= skew_out.execute;
      inst_q[B_LOAD]    <= skew_out.load;

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.cfg_len_nij != '0) begin
              len_q     <= bus.cfg_len_nij;
              mode_q    <= bus.cfg_mode;
              maxpool_q <= bus.cfg_maxpool;
              k         <= '0;
              busy_q    <= 1'b1;
              state     <= EXEC;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        EXEC: begin
          // Addresses hold their last issued value across stalls
          if (issue_c) begin
            inst_q[B_CEN0] <= 1'b0;
            inst_q[B_CEN1] <= 1'b0;
            inst_q[B_A0_LSB +: A_FIELD_W] <= A_FIELD_W'(ADDR_W'(ACT_BASE + k));
            inst_q[B_A1_LSB +: A_FIELD_W] <= A_FIELD_W'(ADDR_W'(W_BASE + k));
            k <= k + ADDR_W'(1);
            if ((k + ADDR_W'(1)) == len_q) begin
              phase_cnt <= '0;
              state     <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (phase_cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
            phase_cnt <= '0;
            state     <= FLUSH;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end

        FLUSH: begin
          if (phase_cnt == CNT_W'(SKEW - 1)) begin
            phase_cnt <= '0;
            rd_cnt    <= '0;
            state     <= READOUT;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end

        READOUT: begin
          if (rd_cnt == CNT_W'(COL)) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (bus.ofifo_valid) begin
            inst_q[B_OFIFO_RD] <= 1'b1;
            inst_q[B_MAX_POOL] <= maxpool_q;
            rd_cnt             <= rd_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/core_inst_sequencer.md
Name: core_inst_sequencer

Overview:
Synthesisable controller that generates the 41-bit core instruction stream for one output-stationary tile pass, in place of hand-driven stimulus. It covers operand fetch/execute, PE drain shift and OFIFO readout with optional max-pool, with correct inter-field skew. It sits between the host/top-level and core.inst, and generalises the pass over runtime length, base addresses, mode and skew depth.

Parameters:
ROW, 8, PE rows
COL, 8, PE columns; number of OFIFO words read per pass
ADDR_W, 8, xmem address width
ACT_BASE, 8'h00, activation base address (A0)
W_BASE, 8'h80, weight base address (A1)
SHIFT_CYCLES, 16, load (drain) cycles after execute; default ROW+COL
SKEW, 3, extra cycles that mode/execute/load lag the memory fields

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low (0 = reset)
start  input  1  one-cycle pulse; begin a pass (IDLE only)
cfg_len_nij  input  ADDR_W  operand vectors per pass; latched at start
cfg_mode  input  1  mode bit for the pass (1 = output-stationary); latched
cfg_maxpool  input  1  drive max_pool_en during readout; latched
l0_ready  input  1  L0 can accept
ififo_ready  input  1  IFIFO can accept
ofifo_valid  input  1  OFIFO holds data
inst  output  41  registered core instruction word
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at end of pass

Behaviour:
- inst map: [40] max_pool_en, [39] psum_bypass=0, [38] acc=0, [37] CEN_pmem=1, [36] WEN_pmem=1, [35:27] A_pmem=0, [26] CEN1, [25:18] A1, [17] CEN0, [16] WEN0, [15:8] A0, [7] ofifo_rd, [6] ififo_wr, [5] ififo_rd, [4] l0_rd, [3] l0_wr, [2] mode, [1] execute, [0] load.
- Reset (reset==0 at a clk edge): state IDLE; CEN0=WEN0=CEN1=CEN_pmem=WEN_pmem=1; all other inst bits 0; busy=0, done=0; skew line and counters cleared. Applies mid-pass too; there is no resume.
- States: IDLE -> EXEC -> SHIFT -> FLUSH -> READOUT -> IDLE.
- IDLE: start with cfg_len_nij!=0 latches cfg and goes to EXEC. start with cfg_len_nij==0 pulses done at the next edge and stays in IDLE. start while busy is ignored.
- EXEC, per cycle, counter k from 0:
  - If l0_ready&ififo_ready: CEN0=0, WEN0=1, CEN1=0, A0=ACT_BASE+k, A1=W_BASE+k (mod 2^ADDR_W). Push {mode=cfg_mode, execute=1, load=0} into the skew line; k++.
  - Else (stall): CEN0=CEN1=1, addresses hold, push {cfg_mode,0,0}.
  - Go to SHIFT when k==cfg_len_nij.
- SHIFT: SHIFT_CYCLES cycles pushing {cfg_mode,0,1}; CEN0=CEN1=1.
- FLUSH: SKEW cycles pushing {0,0,0}, so the skew line is empty on exit.
- Skew line: mode/execute/load on inst appear exactly SKEW cycles after the memory fields of the same issue cycle.
- Derived strobes, one cycle each:
  - l0_wr(t+1) = ~CEN0(t) & WEN0(t); l0_rd(t+1) = l0_wr(t)
  - ififo_wr(t+1) = ~CEN1(t); ififo_rd(t+1) = ififo_wr(t)
- READOUT: each cycle, ofifo_rd = ofifo_valid and max_pool_en = ofifo_valid & cfg_maxpool. Count reads; after COL reads, drive ofifo_rd=0 and pulse done. The next cycle returns to IDLE with busy=0.
- Latency: start at edge 0 gives the first CEN0=0 at edge 1 if ready; the first execute=1 at edge 1+SKEW.
- Address wrap: A0/A1 wrap modulo 2^ADDR_W silently; keeping regions disjoint is the caller's job.

Decomposition:
- Package core_ctrl_pkg holds:
  - INST_W=41
  - bit-position localparams for every inst field
  - state enum {IDLE, EXEC, SHIFT, FLUSH, READOUT}
  - default (reset) inst constant
- Sub-module inst_skew_pipe: parametrised WIDTH=3, DEPTH=SKEW shift register with sync active-low clear.

Test Plan:
- Basic pass: len=27, ready always 1, mode=1 -> 27 contiguous CEN0=0 cycles, A0 0..26, A1 0x80..0x9A. execute=1 for 27 cycles starting 3 cycles after the first CEN0=0. load=1 for 16 cycles. 8 ofifo_rd; one done pulse.
- Stall: deassert l0_ready for cycles 5-8 of EXEC -> CEN0=CEN1=1 and A0 held at 4 during the stall. Exactly 27 issues total; execute gaps appear 3 cycles later.
- Strobes: single issue at cycle T -> l0_wr=1 and ififo_wr=1 only at T+1; l0_rd=1 and ififo_rd=1 only at T+2.
- Readout: cfg_maxpool=1, ofifo_valid toggled 1,0,1... -> ofifo_rd and max_pool_en track valid; done after the 8th read. A run with cfg_maxpool=0 keeps max_pool_en=0.
- Reset mid-EXEC: reset=0 at k=10 -> next edge shows the inst default (CEN0=1, execute=0), busy=0. A new start with len=4 runs a clean 4-issue pass from A0=0.
- Edge cases:
  - len=0 start -> done at the next edge with no CEN0 activity.
  - start pulsed during EXEC -> ignored.
  - ACT_BASE=0xFE, len=4 -> A0 = FE, FF, 00, 01.
